// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core. It drives the datapath selects, the write enables
// and ALUOp for each cycle of lw, sw, R-type, I-type, beq and jal.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  state_t state_q, state_next;
  ctrl_t  ctrl_q;
  logic   legal_op;

  // Moore outputs decoded for a given state; registered from the next state so they line up with state_q
  function automatic ctrl_t moore_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      ALUWB:    c.reg_write = 1'b1;
      BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.jump      = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    legal_op = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: legal_op = 1'b1;
      default: legal_op = 1'b0;
    endcase
  end

  always_comb begin
    state_next = FETCH;
    case (state_q)
      FETCH:    state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_JAL:       state_next = JAL;
          OP_BEQ:       state_next = BEQ;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
      EXECUTER, EXECUTEI, JAL: state_next = ALUWB;
      ALUWB, BEQ: state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctrl_q  <= moore_ctrl(FETCH);
    end else begin
      state_q <= state_next;
      ctrl_q  <= moore_ctrl(state_next);
    end
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Only IRWrite, PCWrite and illegal bypass the output registers: they track mem_ready, zero and opcode in the same cycle
  assign IRWrite   = (state_q == FETCH) && mem_ready;
  assign PCWrite   = IRWrite || ctrl_q.jump || (ctrl_q.branch && zero);
  assign illegal   = (state_q == DECODE) && !legal_op;
  assign AdrSrc    = ctrl_q.adr_src;
  assign MemWrite  = ctrl_q.mem_write;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ALUOp     = ctrl_q.alu_op;
  assign RegWrite  = ctrl_q.reg_write;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Each cycle checks every output against hand-written values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0] state;
  logic [1:0] exp_imm;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] observed();
    return {12'd0, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ALUOp, RegWrite, ImmSrc, illegal, state};
  endfunction

  // Vector order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ALUOp RegWrite ImmSrc illegal state
  task automatic cyc(input string tag, input logic mr, input logic z, input logic [3:0] st,
                     input logic pcw, input logic adr, input logic mw, input logic irw,
                     input logic [1:0] rs, input logic [1:0] asa, input logic [1:0] asb,
                     input logic [1:0] aop, input logic rw, input logic ill);
    mem_ready = mr;
    zero      = z;
    #4;
    check(tag, observed(), {12'd0, pcw, adr, mw, irw, rs, asa, asb, aop, rw, exp_imm, ill, st});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string tag);
    cyc({tag, "_f"}, 1, 0, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    cyc({tag, "_d"}, 1, 0, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0);
  endtask

  initial begin
    rst_n = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 7'b0000011; exp_imm = 2'b00;
    #1 rst_n = 1'b0;
    #1 check("rst_vec", observed(), {12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0});
    mem_ready = 1'b1;
    #1 check("rst_irw_pcw", {30'd0, IRWrite, PCWrite}, 32'd3);
    mem_ready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // lw, no stalls: 0,1,2,3,4
    opcode = 7'b0000011; exp_imm = 2'b00;
    fetch_decode("lw");
    cyc("lw_adr", 1, 0, 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
    cyc("lw_rd",  1, 0, 4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("lw_wb",  1, 0, 4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);

    // sw with two stall cycles in MEMWRITE
    opcode = 7'b0100011; exp_imm = 2'b01;
    fetch_decode("sw");
    cyc("sw_adr", 1, 0, 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
    cyc("sw_w0",  0, 0, 4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("sw_w1",  0, 0, 4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("sw_w2",  1, 0, 4'd5, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);

    // beq taken then not taken
    opcode = 7'b1100011; exp_imm = 2'b10;
    fetch_decode("beq_t");
    cyc("beq_t_br", 1, 1, 4'd10, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
    fetch_decode("beq_n");
    cyc("beq_n_br", 1, 0, 4'd10, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);

    // R-type, with a one-cycle fetch stall first
    opcode = 7'b0110011; exp_imm = 2'b00;
    cyc("r_fstall", 0, 0, 4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    fetch_decode("r");
    cyc("r_ex", 1, 0, 4'd6, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
    cyc("r_wb", 1, 0, 4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);

    // jal
    opcode = 7'b1101111; exp_imm = 2'b11;
    fetch_decode("jal");
    cyc("jal_ex", 1, 0, 4'd9, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);
    cyc("jal_wb", 1, 0, 4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);

    // I-type
    opcode = 7'b0010011; exp_imm = 2'b00;
    fetch_decode("i");
    cyc("i_ex", 1, 0, 4'd8, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0);
    cyc("i_wb", 1, 0, 4'd7, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);

    // illegal opcode: one pulse in DECODE, then straight back to FETCH
    opcode = 7'b0000000; exp_imm = 2'b00;
    cyc("ill_f", 1, 0, 4'd0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    cyc("ill_d", 1, 0, 4'd1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 1);
    cyc("ill_back", 0, 0, 4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);

    // async reset while MEMWRITE is stalled
    opcode = 7'b0100011; exp_imm = 2'b01;
    fetch_decode("swr");
    cyc("swr_adr", 1, 0, 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
    mem_ready = 1'b0;
    #2 check("swr_pre", {27'd0, MemWrite, state}, {27'd0, 1'b1, 4'd5});
    rst_n = 1'b0;
    #1 check("swr_rst", {26'd0, AdrSrc, MemWrite, state}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    opcode = 7'b0000011; exp_imm = 2'b00;
    fetch_decode("post");
    cyc("post_adr", 1, 0, 4'd2, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
    cyc("post_rd",  1, 0, 4'd3, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    cyc("post_wb",  1, 0, 4'd4, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0);
    cyc("post_f",   0, 0, 4'd0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
